// File: rtl/fp_pkg.sv
// Shared constants and encodings for the single-precision multiplier datapath.
package fp_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned BIAS   = 127;

   localparam logic [31:0]      QNAN    = 32'h7FC00000;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      SPEC_NORMAL = 2'b00,
      SPEC_ZERO   = 2'b01,
      SPEC_INF    = 2'b10,
      SPEC_NAN    = 2'b11
   } spec_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized 24-bit significand using guard/sticky bits.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [FRAC_W:0]   sig_i,
   input  logic              g_i,
   input  logic              s_i,
   output logic [FRAC_W-1:0] frac_o,
   output logic              carry_o
);

   logic              up;
   logic [FRAC_W+1:0] sum;

   assign up      = g_i & (s_i | sig_i[0]);
   assign sum     = {1'b0, sig_i} + {{(FRAC_W + 1){1'b0}}, up};
   assign carry_o = sum[FRAC_W+1];
   // On carry-out the hidden bit drops to 0, which clears the fraction.
   assign frac_o  = sum[FRAC_W-1:0] & {FRAC_W{sum[FRAC_W]}};

endmodule

// File: rtl/fp_mul_normalizer.sv
// Post-multiply normalize/round stage: raw product in, packed IEEE-754 single out.
module fp_mul_normalizer
   import fp_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exp,
   input  logic [47:0] in_mant,
   input  logic [1:0]  in_spec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result
);

   state_e             state_q, state_d;
   logic               sign_q, sign_d;
   logic [9:0]         exp_q, exp_d;
   logic [47:0]        mant_q, mant_d;
   spec_e              spec_q, spec_d;
   logic [FRAC_W:0]    sig_q, sig_d;
   logic               g_q, g_d;
   logic               s_q, s_d;
   logic signed [10:0] e_q, e_d;
   logic [31:0]        res_q, res_d;

   logic [FRAC_W-1:0]  rnd_frac;
   logic               rnd_carry;
   logic signed [10:0] e_base;
   logic signed [10:0] e_rnd;

   fp_round_rne u_round (
      .sig_i   (sig_q),
      .g_i     (g_q),
      .s_i     (s_q),
      .frac_o  (rnd_frac),
      .carry_o (rnd_carry)
   );

   assign e_base = $signed({1'b0, exp_q} - 11'(BIAS));
   assign e_rnd  = e_q + $signed({10'd0, rnd_carry});

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mant_q  <= '0;
         spec_q  <= SPEC_NORMAL;
         sig_q   <= '0;
         g_q     <= 1'b0;
         s_q     <= 1'b0;
         e_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         spec_q  <= spec_d;
         sig_q   <= sig_d;
         g_q     <= g_d;
         s_q     <= s_d;
         e_q     <= e_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      spec_d  = spec_q;
      sig_d   = sig_q;
      g_d     = g_q;
      s_d     = s_q;
      e_d     = e_q;
      res_d   = res_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sign_d  = in_sign;
               exp_d   = in_exp;
               mant_d  = in_mant;
               spec_d  = spec_e'(in_spec);
               state_d = ST_NORM;
            end
         end

         ST_NORM: begin
            if (mant_q[47]) begin
               sig_d = mant_q[47:24];
               g_d   = mant_q[23];
               s_d   = |mant_q[22:0];
               e_d   = e_base + 11'sd1;
            end else begin
               sig_d = mant_q[46:23];
               g_d   = mant_q[22];
               s_d   = |mant_q[21:0];
               e_d   = e_base;
            end
            state_d = ST_ROUND;
         end

         ST_ROUND: begin
            case (spec_q)
               SPEC_NAN:  res_d = QNAN;
               SPEC_INF:  res_d = {sign_q, EXP_MAX, 23'h0};
               SPEC_ZERO: res_d = {sign_q, 31'h0};
               default: begin
                  if (e_rnd >= 11'sd255)
                     res_d = {sign_q, EXP_MAX, 23'h0};
                  else if (e_rnd <= 11'sd0)
                     res_d = {sign_q, 31'h0};
                  else
                     res_d = {sign_q, e_rnd[7:0], rnd_frac};
               end
            endcase
            state_d = ST_DONE;
         end

         ST_DONE: begin
            if (out_ready)
               state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign out_result = res_q;

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Self-checking bench for fp_mul_normalizer against an arithmetic reference model.
module tb_fp_mul_normalizer;

   logic        CLK;
   logic        RST_N;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic [1:0]  in_spec;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;

   int errors = 0;
   int checks = 0;

   fp_mul_normalizer dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .in_spec    (in_spec),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        s;
      logic [9:0]  e;
      logic [47:0] m;
      logic [1:0]  sp;
      logic [31:0] res;
   } vec_t;

   // Value-level reference: shift the product to 24 significant bits, then
   // round on the discarded remainder compared against exactly one half ulp.
   function automatic logic [31:0] ref_result(input logic s, input logic [9:0] ex,
                                              input logic [47:0] m, input logic [1:0] sp);
      longint unsigned p, q, rem, half;
      int sh, e;
      if (sp == 2'b11) return 32'h7FC00000;
      if (sp == 2'b10) return {s, 8'hFF, 23'h0};
      if (sp == 2'b01) return {s, 31'h0};
      p    = longint'(m);
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      e = int'(ex) - 127 + (sh - 23);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), q[22:0]};
   endfunction

   // Issue one product from a negedge, wait (bounded) for out_valid, then handshake.
   task automatic send_and_get(input logic s, input logic [9:0] ex, input logic [47:0] m,
                               input logic [1:0] sp, output logic [31:0] res, output int lat);
      in_sign  = s;
      in_exp   = ex;
      in_mant  = m;
      in_spec  = sp;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      in_sign  = 1'($urandom);
      in_exp   = 10'($urandom);
      in_mant  = {16'($urandom), 32'($urandom)};
      in_spec  = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      if (!out_valid) lat = 99;
      res = out_result;
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      RST_N     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      in_spec   = '0;
      #12;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_out_result: got %h want 00000000", out_result);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_directed;
      vec_t tbl[17];
      logic [31:0] res;
      int lat;
      tbl = '{
         '{1'b0, 10'd254, 48'h900000000000, 2'd0, 32'h40100000},
         '{1'b0, 10'd256, 48'h600000000000, 2'd0, 32'h40C00000},
         '{1'b1, 10'd256, 48'h600000000000, 2'd0, 32'hC0C00000},
         '{1'b0, 10'd254, 48'hFFFFFF800000, 2'd0, 32'h40800000},
         '{1'b0, 10'd254, 48'h800001800000, 2'd0, 32'h40000002},
         '{1'b0, 10'd254, 48'h800000800000, 2'd0, 32'h40000000},
         '{1'b0, 10'd508, 48'h400000000000, 2'd0, 32'h7F800000},
         '{1'b0, 10'd2,   48'h400000000000, 2'd0, 32'h00000000},
         '{1'b1, 10'd254, 48'h900000000000, 2'd3, 32'h7FC00000},
         '{1'b1, 10'd254, 48'h900000000000, 2'd2, 32'hFF800000},
         '{1'b1, 10'd254, 48'h900000000000, 2'd1, 32'h80000000},
         '{1'b0, 10'd381, 48'h400000000000, 2'd0, 32'h7F000000},
         '{1'b0, 10'd382, 48'h400000000000, 2'd0, 32'h7F800000},
         '{1'b0, 10'd128, 48'h400000000000, 2'd0, 32'h00800000},
         '{1'b0, 10'd127, 48'h400000000000, 2'd0, 32'h00000000},
         '{1'b0, 10'd380, 48'hFFFFFF800000, 2'd0, 32'h7F800000},
         '{1'b0, 10'd126, 48'hFFFFFF800000, 2'd0, 32'h00800000}
      };
      for (int i = 0; i < 17; i++) begin
         send_and_get(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].sp, res, lat);
         checks++;
         if (lat !== 3) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d cycles want 3", i, lat);
         end
         checks++;
         if (res !== tbl[i].res) begin
            errors++;
            $display("FAIL directed_result[%0d]: got %h want %h", i, res, tbl[i].res);
         end
      end
   endtask

   task automatic test_random;
      logic [22:0] fa, fb;
      logic [47:0] m;
      logic [9:0]  ex;
      logic        s;
      logic [1:0]  sp;
      logic [31:0] res, want;
      int lat, r;
      for (int i = 0; i < 200; i++) begin
         fa = 23'($urandom);
         fb = 23'($urandom);
         m  = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
         if ($urandom_range(0, 3) == 0) begin
            if (m[47]) m[22:0] = '0;
            else m[21:0] = '0;
         end
         ex = 10'($urandom_range(0, 510));
         s  = 1'($urandom);
         r  = int'($urandom_range(0, 9));
         sp = (r < 7) ? 2'd0 : 2'(r - 6);
         want = ref_result(s, ex, m, sp);
         send_and_get(s, ex, m, sp, res, lat);
         checks++;
         if (lat !== 3) begin
            errors++;
            $display("FAIL random_latency[%0d]: got %0d cycles want 3", i, lat);
         end
         checks++;
         if (res !== want) begin
            errors++;
            $display("FAIL random_result[%0d]: exp=%0d mant=%h spec=%0d got %h want %h",
                     i, ex, m, sp, res, want);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] want0, want1, held;
      int n;
      want0 = ref_result(1'b0, 10'd250, 48'h900000000000, 2'd0);
      want1 = ref_result(1'b1, 10'd260, 48'hC3A5F0123456, 2'd0);
      in_sign  = 1'b0;
      in_exp   = 10'd250;
      in_mant  = 48'h900000000000;
      in_spec  = 2'd0;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_sign = 1'b1;
      in_exp  = 10'd260;
      in_mant = 48'hC3A5F0123456;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge CLK);
         n++;
      end
      held = out_result;
      checks++;
      if (held !== want0) begin
         errors++;
         $display("FAIL bp_first_result: got %h want %h", held, want0);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         checks++;
         if (out_valid !== 1'b1 || out_result !== want0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b result=%h in_ready=%b want 1/%h/0",
                     k, out_valid, out_result, in_ready, want0);
         end
      end
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_second_accept: in_ready=%b want 0", in_ready);
      end
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL bp_second_latency: got %0d cycles want 3", n);
      end
      checks++;
      if (out_result !== want1) begin
         errors++;
         $display("FAIL bp_second_result: got %h want %h", out_result, want1);
      end
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] res, want;
      int lat;
      in_sign  = 1'b0;
      in_exp   = 10'd256;
      in_mant  = 48'h600000000000;
      in_spec  = 2'd0;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      @(posedge CLK);
      #3;
      RST_N = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_clear: valid=%b result=%h in_ready=%b want 0/00000000/1",
                  out_valid, out_result, in_ready);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale[%0d]: out_valid=%b want 0", k, out_valid);
         end
      end
      want = ref_result(1'b1, 10'd254, 48'h900000000000, 2'd0);
      send_and_get(1'b1, 10'd254, 48'h900000000000, 2'd0, res, lat);
      checks++;
      if (lat !== 3 || res !== want) begin
         errors++;
         $display("FAIL midreset_next: lat=%0d result=%h want 3/%h", lat, res, want);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
